prim_clock_switch_ctrl: RTL and testbench
=========================================

Name: prim_clock_switch_ctrl

Overview:
- Sequencer that drives a two-input glitch-prone clock mux safely.
- It accepts switch requests over a valid/ready handshake.
- For each request it gates the currently selected source, waits, flips the mux select, waits again, then ungates the new source.
- Runs on an always-on clock; drives sel and the clock-gate enables for the parent's clock mux and gates.

Parameters:
- GateCycles, 4, cycles held in GATE after disabling the current clock enable (must be >= 1).
- SettleCycles, 4, cycles held in SWITCH after changing select, before enabling the new clock (must be >= 1).
- ResetSel, 1'b0, select value and enabled source after reset.

Ports:
- clk_i  in  1  always-on controller clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  switch request valid
- req_sel_i  in  1  requested source (0 = clk0, 1 = clk1)
- req_ready_o  out  1  request can be accepted
- clk_ok_i  in  2  per-source "clock present" from the clock monitors; bit n = source n
- sel_o  out  1  mux select to the clock mux
- clk_en_o  out  2  clock-gate enables; bit n gates source n
- busy_o  out  1  switch sequence in progress
- done_o  out  1  one-cycle pulse: request completed
- err_o  out  1  one-cycle pulse: request rejected

Behaviour:
- Reset (async, rst_ni=0):
  - state = IDLE, sel_o = ResetSel
  - clk_en_o[ResetSel] = 1, other enable bit = 0
  - busy_o = 0, done_o = 0, err_o = 0, counter = 0
  - Reset mid-sequence aborts immediately to these values.
- All outputs are registered except req_ready_o, which equals (state == IDLE).
- Acceptance: a request is accepted on a clk_i edge where req_valid_i & req_ready_o. Requests outside IDLE are not accepted; the requester holds valid.
- Decision at acceptance, mutually exclusive, evaluated in this priority:
  1. clk_ok_i[req_sel_i] = 0: err_o = 1 the next cycle; no other change; stay IDLE.
  2. req_sel_i == sel_o and target ok: done_o = 1 the next cycle; no gating; stay IDLE.
  3. Otherwise: go to GATE.
- FSM states: IDLE, GATE, SWITCH.
- IDLE -> GATE (on accepted switch):
  - clk_en_o[sel_o] <- 0, busy_o <- 1, counter <- GateCycles-1
  - target latched into a register.
- GATE: both enables 0. Decrement counter. At counter == 0, go to SWITCH with sel_o <- target and counter <- SettleCycles-1.
- SWITCH: both enables 0, sel_o = target. Decrement counter. At counter == 0, go to IDLE with clk_en_o[target] <- 1, busy_o <- 0, done_o <- 1 for one cycle.
- Latency: acceptance at edge 0 gives done_o high in cycle 1+GateCycles+SettleCycles. Defaults give cycle 9.
- Enable invariant: clk_en_o never has both bits set. sel_o changes only while clk_en_o == 0.
- clk_ok_i is sampled only at acceptance. Later drops are ignored; supervision belongs to the parent.
- Back-to-back: a new request can be accepted in the same cycle done_o is high, since state is IDLE.
- Counter width: $clog2(max(GateCycles, SettleCycles)) with a minimum of 1 bit. No wrap: the counter is reloaded on every state entry.
- done_o and err_o are never high in the same cycle.

Decomposition:
- Package prim_clock_switch_pkg holds the state enum (IDLE, GATE, SWITCH) as a 2-bit encoded typedef. Unused encodings decode to IDLE.
- No sub-module: the wait counter is inline.
- The parent instantiates the clock mux and clock gates. This block only drives sel and the enables.

Test Plan:
- Reset release, no requests -> sel_o = 0, clk_en_o = 2'b01, req_ready_o = 1, busy_o = 0, for 20 cycles.
- Request sel = 1 with clk_ok_i = 2'b11 at cycle 0:
  - clk_en_o = 2'b00 from cycle 1.
  - sel_o = 1 from cycle 5.
  - clk_en_o = 2'b10 and done_o pulse in cycle 9.
  - busy_o high in cycles 1-8; req_ready_o low in cycles 1-8.
- Request sel = 1 with clk_ok_i = 2'b01 -> err_o pulse next cycle; sel_o, clk_en_o, busy_o unchanged.
- Request sel = 0 while sel_o = 0 -> done_o pulse next cycle; clk_en_o stays 2'b01 throughout.
- Valid held during a switch with a second request (sel = 0) -> accepted in the done_o cycle of the first switch; second done_o 9 cycles later; final sel_o = 0, clk_en_o = 2'b01.
- Assert rst_ni in cycle 6 of a switch to 1 -> outputs return asynchronously to sel_o = 0, clk_en_o = 2'b01, busy_o = 0; assertion-check that clk_en_o is never 2'b11 across all tests.

Source files
------------

// File: rtl/prim_clock_switch_pkg.sv
// Shared types and helpers for the glitch-free clock switch sequencer.
package prim_clock_switch_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StGate   = 2'b01,
        StSwitch = 2'b10
    } state_e;

    // One-hot clock-gate enable for the given mux select.
    function automatic logic [1:0] sel_to_en(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/prim_clock_switch_ctrl.sv
// Sequences a two-input clock mux: gate current source, wait, flip select, wait, ungate new source.
module prim_clock_switch_ctrl
    import prim_clock_switch_pkg::*;
#(
    parameter int unsigned GateCycles   = 4,
    parameter int unsigned SettleCycles = 4,
    parameter logic        ResetSel     = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    input  logic       req_sel_i,
    output logic       req_ready_o,
    input  logic [1:0] clk_ok_i,
    output logic       sel_o,
    output logic [1:0] clk_en_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int unsigned MaxCycles = (GateCycles > SettleCycles) ? GateCycles : SettleCycles;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] GateLoad   = CntW'(GateCycles - 1);
    localparam logic [CntW-1:0] SettleLoad = CntW'(SettleCycles - 1);

    state_e          state_q, state_d;
    logic            sel_q, sel_d;
    logic            tgt_q, tgt_d;
    logic [1:0]      en_q, en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept;

    assign req_ready_o = (state_q == StIdle);
    assign accept      = req_valid_i & req_ready_o;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tgt_d   = tgt_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!clk_ok_i[req_sel_i]) begin
                        err_d = 1'b1;
                    end else if (req_sel_i == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StGate;
                        en_d    = 2'b00;
                        busy_d  = 1'b1;
                        cnt_d   = GateLoad;
                        tgt_d   = req_sel_i;
                    end
                end
            end
            StGate: begin
                en_d = 2'b00;
                if (cnt_q == '0) begin
                    state_d = StSwitch;
                    sel_d   = tgt_q;
                    cnt_d   = SettleLoad;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StSwitch: begin
                en_d = 2'b00;
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    en_d    = sel_to_en(tgt_q);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                // Illegal encoding: fall back to idle with the current select's source enabled.
                state_d = StIdle;
                en_d    = sel_to_en(sel_q);
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            sel_q   <= ResetSel;
            tgt_q   <= ResetSel;
            en_q    <= sel_to_en(ResetSel);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tgt_q   <= tgt_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel_o    = sel_q;
    assign clk_en_o = en_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_prim_clock_switch_ctrl.sv
// Directed, table-driven bench for prim_clock_switch_ctrl with default parameters.
module tb_prim_clock_switch_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       req_valid_i;
    logic       req_sel_i;
    logic       req_ready_o;
    logic [1:0] clk_ok_i;
    logic       sel_o;
    logic [1:0] clk_en_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_inv_bad = 0;

    always #5 clk_i = ~clk_i;

    prim_clock_switch_ctrl dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_sel_i   (req_sel_i),
        .req_ready_o (req_ready_o),
        .clk_ok_i    (clk_ok_i),
        .sel_o       (sel_o),
        .clk_en_o    (clk_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    // Expected vector bit order: {sel, en[1:0], busy, done, err, ready}
    typedef struct {
        logic       valid;
        logic       sel;
        logic [1:0] ok;
        logic [6:0] exp;
    } vec_t;

    localparam logic [6:0] Idle0 = 7'b0_01_0001;

    vec_t vecs[15];

    function automatic logic [6:0] obs();
        return {sel_o, clk_en_o, busy_o, done_o, err_o, req_ready_o};
    endfunction

    task automatic chk(input string name, input int idx, input logic [6:0] act,
                       input logic [6:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input logic v, input logic s, input logic [1:0] ok);
        req_valid_i = v;
        req_sel_i   = s;
        clk_ok_i    = ok;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        req_valid_i = 1'b0;
        req_sel_i   = 1'b0;
        clk_ok_i    = 2'b11;
        rst_ni      = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Both enables high at once would let two clocks through the mux.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && clk_en_o === 2'b11) begin
            n_inv_bad++;
            $display("FAIL en_invariant: got clk_en_o %b", clk_en_o);
        end
    end

    initial begin
        int first_done;
        int second_done;

        vecs[0]  = '{1'b0, 1'b0, 2'b11, 7'b0_01_0001};
        vecs[1]  = '{1'b1, 1'b1, 2'b01, 7'b0_01_0011}; // target clock missing
        vecs[2]  = '{1'b1, 1'b0, 2'b11, 7'b0_01_0101}; // already selected
        vecs[3]  = '{1'b1, 1'b0, 2'b10, 7'b0_01_0011}; // error outranks no-op
        vecs[4]  = '{1'b1, 1'b1, 2'b11, 7'b0_00_1000}; // cycle 1
        vecs[5]  = '{1'b0, 1'b0, 2'b11, 7'b0_00_1000};
        vecs[6]  = '{1'b0, 1'b0, 2'b00, 7'b0_00_1000}; // ok drop ignored
        vecs[7]  = '{1'b0, 1'b0, 2'b11, 7'b0_00_1000};
        vecs[8]  = '{1'b0, 1'b0, 2'b11, 7'b1_00_1000}; // cycle 5: select flips
        vecs[9]  = '{1'b0, 1'b0, 2'b11, 7'b1_00_1000};
        vecs[10] = '{1'b0, 1'b0, 2'b11, 7'b1_00_1000};
        vecs[11] = '{1'b0, 1'b0, 2'b11, 7'b1_00_1000};
        vecs[12] = '{1'b0, 1'b0, 2'b11, 7'b1_10_0101}; // cycle 9: done
        vecs[13] = '{1'b0, 1'b0, 2'b11, 7'b1_10_0001};
        vecs[14] = '{1'b1, 1'b1, 2'b10, 7'b1_10_0101};

        do_reset();
        chk("reset", 0, obs(), Idle0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 2'b11);
            chk("idle", i, obs(), Idle0);
        end

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].valid, vecs[i].sel, vecs[i].ok);
            chk("vec", i, obs(), vecs[i].exp);
        end

        // Back-to-back: valid held, second request accepted in the first done cycle.
        do_reset();
        step(1'b1, 1'b1, 2'b11);
        req_sel_i   = 1'b0;
        first_done  = -1;
        second_done = -1;
        for (int c = 1; c < 40 && second_done < 0; c++) begin
            if (done_o) begin
                if (first_done < 0) begin
                    first_done = c;
                end else begin
                    second_done = c;
                    req_valid_i = 1'b0;
                end
            end
            if (second_done < 0) begin
                @(posedge clk_i);
                @(negedge clk_i);
            end
        end
        chk_int("b2b_first_done_cycle", first_done, 9);
        chk_int("b2b_second_done_cycle", second_done, 18);
        chk("b2b_final", 0, obs(), 7'b0_01_0101);
        step(1'b0, 1'b0, 2'b11);
        chk("b2b_after", 0, obs(), Idle0);

        // Asynchronous reset in cycle 6 of a switch to source 1.
        do_reset();
        step(1'b1, 1'b1, 2'b11);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'b11);
        chk("pre_abort", 0, obs(), 7'b1_00_1000);
        #2 rst_ni = 1'b0;
        #1 chk("async_abort", 0, obs(), Idle0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(1'b0, 1'b0, 2'b11);
        chk("post_abort", 0, obs(), Idle0);

        chk_int("en_invariant_violations", n_inv_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
